// File: rtl/ex_mem_branch_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_branch_stage
//
// EX/MEM pipeline register of the RV32I pipeline, directly after the ALU.
// Captures the ALU result and flags together with the EX control bundle.
// Resolves conditional branches, JAL and JALR, and issues a one-shot redirect
// to the front end. It also squashes the single wrong-path instruction that
// follows a taken transfer into this stage.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall_i                    hold all registered state (MEM backpressure)
//   flush_i                    trap flush: load a bubble (beats stall_i)
//   valid_i                    EX slot holds a real instruction
//   alu_out_i, zero/sf/cf/vf_i ALU result and flags (A + ~B + 1 path)
//   rs2_data_i, pc_i, imm_i    store data, EX PC, sign-extended immediate
//   rd_i, funct3_i             destination register, branch/memory funct3
//   branch_i, jal_i, jalr_i    control-transfer class
//   mem_read_i .. mem_to_reg_i downstream control
//   valid_o .. mem_to_reg_o    registered MEM slot (control gated by valid)
//   redirect_o, redirect_pc_o  one-cycle redirect pulse and its target
//   misalign_o                 taken target has bit 1 set
//   taken_cnt_o                number of redirects issued (wraps)
// ---------------------------------------------------------------------------
module ex_mem_branch_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [N-1:0] alu_out_i,
    input  logic         zero_i,
    input  logic         sf_i,
    input  logic         cf_i,
    input  logic         vf_i,
    input  logic [N-1:0] rs2_data_i,
    input  logic [N-1:0] pc_i,
    input  logic [N-1:0] imm_i,
    input  logic [4:0]   rd_i,
    input  logic [2:0]   funct3_i,
    input  logic         branch_i,
    input  logic         jal_i,
    input  logic         jalr_i,
    input  logic         mem_read_i,
    input  logic         mem_write_i,
    input  logic         reg_write_i,
    input  logic         mem_to_reg_i,
    output logic         valid_o,
    output logic [N-1:0] result_o,
    output logic [N-1:0] rs2_data_o,
    output logic [4:0]   rd_o,
    output logic [2:0]   funct3_o,
    output logic         mem_read_o,
    output logic         mem_write_o,
    output logic         reg_write_o,
    output logic         mem_to_reg_o,
    output logic         redirect_o,
    output logic [N-1:0] redirect_pc_o,
    output logic         misalign_o,
    output logic [31:0]  taken_cnt_o
);

    // Registered state
    logic         valid_q,       valid_d;
    logic [N-1:0] result_q,      result_d;
    logic [N-1:0] rs2_data_q,    rs2_data_d;
    logic [4:0]   rd_q,          rd_d;
    logic [2:0]   funct3_q,      funct3_d;
    logic         mem_read_q,    mem_read_d;
    logic         mem_write_q,   mem_write_d;
    logic         reg_write_q,   reg_write_d;
    logic         mem_to_reg_q,  mem_to_reg_d;
    logic         redirect_q,    redirect_d;
    logic [N-1:0] redirect_pc_q, redirect_pc_d;
    logic         misalign_q,    misalign_d;
    logic [31:0]  taken_cnt_q,   taken_cnt_d;
    logic         kill_pending_q, kill_pending_d;
    logic         redirect_done_q, redirect_done_d;

    // Branch resolution
    logic         predicate;
    logic         take;
    logic [N-1:0] target;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        predicate = 1'b0;
        unique case (funct3_i)
            3'b000:  predicate = zero_i;          // BEQ
            3'b001:  predicate = ~zero_i;         // BNE
            3'b100:  predicate = sf_i ^ vf_i;     // BLT
            3'b101:  predicate = ~(sf_i ^ vf_i);  // BGE
            3'b110:  predicate = ~cf_i;           // BLTU
            3'b111:  predicate = cf_i;            // BGEU
            default: predicate = 1'b0;            // 010/011 never branch
        endcase

        take = valid_i & (jal_i | jalr_i | (branch_i & predicate));

        // JALR clears bit 0 of the computed address; sums wrap mod 2^N.
        if (jalr_i) begin
            target = {alu_out_i[N-1:1], 1'b0};
        end else begin
            target = pc_i + imm_i;
        end
    end

    always_comb begin
        // Default: hold everything (this is also the stall behaviour).
        valid_d         = valid_q;
        result_d        = result_q;
        rs2_data_d      = rs2_data_q;
        rd_d            = rd_q;
        funct3_d        = funct3_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        reg_write_d     = reg_write_q;
        mem_to_reg_d    = mem_to_reg_q;
        redirect_d      = redirect_q;
        redirect_pc_d   = redirect_pc_q;
        misalign_d      = misalign_q;
        taken_cnt_d     = taken_cnt_q;
        kill_pending_d  = kill_pending_q;
        redirect_done_d = redirect_done_q;

        if (flush_i || (!stall_i && kill_pending_q)) begin
            // Bubble: either a trap flush or the squashed wrong-path slot.
            valid_d         = 1'b0;
            result_d        = '0;
            rs2_data_d      = '0;
            rd_d            = '0;
            funct3_d        = '0;
            mem_read_d      = 1'b0;
            mem_write_d     = 1'b0;
            reg_write_d     = 1'b0;
            mem_to_reg_d    = 1'b0;
            redirect_d      = 1'b0;
            misalign_d      = 1'b0;
            kill_pending_d  = 1'b0;
            redirect_done_d = 1'b0;
        end else if (stall_i) begin
            // Registers hold, but once the pulse has been seen for one cycle it
            // is masked so a held redirect is not issued again.
            redirect_done_d = redirect_done_q | redirect_q;
        end else begin
            valid_d         = valid_i;
            result_d        = (jal_i | jalr_i) ? pc_i + N'(4) : alu_out_i;
            rs2_data_d      = rs2_data_i;
            rd_d            = rd_i;
            funct3_d        = funct3_i;
            mem_read_d      = mem_read_i   & valid_i;
            mem_write_d     = mem_write_i  & valid_i;
            reg_write_d     = reg_write_i  & valid_i;
            mem_to_reg_d    = mem_to_reg_i & valid_i;
            redirect_d      = take;
            redirect_pc_d   = target;
            misalign_d      = take & target[1];
            kill_pending_d  = take;
            redirect_done_d = 1'b0;
            if (take) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= 1'b0;
            result_q        <= '0;
            rs2_data_q      <= '0;
            rd_q            <= '0;
            funct3_q        <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            misalign_q      <= 1'b0;
            taken_cnt_q     <= '0;
            kill_pending_q  <= 1'b0;
            redirect_done_q <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            result_q        <= result_d;
            rs2_data_q      <= rs2_data_d;
            rd_q            <= rd_d;
            funct3_q        <= funct3_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            misalign_q      <= misalign_d;
            taken_cnt_q     <= taken_cnt_d;
            kill_pending_q  <= kill_pending_d;
            redirect_done_q <= redirect_done_d;
        end
    end

    assign valid_o       = valid_q;
    assign result_o      = result_q;
    assign rs2_data_o    = rs2_data_q;
    assign rd_o          = rd_q;
    assign funct3_o      = funct3_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign reg_write_o   = reg_write_q;
    assign mem_to_reg_o  = mem_to_reg_q;
    assign redirect_o    = redirect_q & ~redirect_done_q;
    assign redirect_pc_o = redirect_pc_q;
    assign misalign_o    = misalign_q;
    assign taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_branch_stage
//
// Directed bench for ex_mem_branch_stage. Each task drives one scenario and
// compares outputs against hand-computed values. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point, well away from the edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_branch_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall_i, flush_i, valid_i;
    logic [N-1:0] alu_out_i;
    logic         zero_i, sf_i, cf_i, vf_i;
    logic [N-1:0] rs2_data_i, pc_i, imm_i;
    logic [4:0]   rd_i;
    logic [2:0]   funct3_i;
    logic         branch_i, jal_i, jalr_i;
    logic         mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
    logic         valid_o;
    logic [N-1:0] result_o, rs2_data_o;
    logic [4:0]   rd_o;
    logic [2:0]   funct3_o;
    logic         mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o;
    logic         redirect_o;
    logic [N-1:0] redirect_pc_o;
    logic         misalign_o;
    logic [31:0]  taken_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    ex_mem_branch_stage #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .alu_out_i(alu_out_i), .zero_i(zero_i),
        .sf_i(sf_i), .cf_i(cf_i), .vf_i(vf_i), .rs2_data_i(rs2_data_i),
        .pc_i(pc_i), .imm_i(imm_i), .rd_i(rd_i), .funct3_i(funct3_i),
        .branch_i(branch_i), .jal_i(jal_i), .jalr_i(jalr_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
        .valid_o(valid_o), .result_o(result_o), .rs2_data_o(rs2_data_o),
        .rd_o(rd_o), .funct3_o(funct3_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
        .mem_to_reg_o(mem_to_reg_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .misalign_o(misalign_o),
        .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_i = 0; flush_i = 0; valid_i = 0;
        alu_out_i = '0; zero_i = 0; sf_i = 0; cf_i = 0; vf_i = 0;
        rs2_data_i = '0; pc_i = '0; imm_i = '0; rd_i = '0; funct3_i = '0;
        branch_i = 0; jal_i = 0; jalr_i = 0;
        mem_read_i = 0; mem_write_i = 0; reg_write_i = 0; mem_to_reg_i = 0;
    endtask

    // Plain ALU instruction writing rd
    task automatic drive_alu(input logic [N-1:0] res, input logic [4:0] rd);
        drive_idle();
        valid_i = 1; alu_out_i = res; rd_i = rd; reg_write_i = 1;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [N-1:0] pc,
                                input logic [N-1:0] imm, input logic z,
                                input logic c);
        drive_idle();
        valid_i = 1; branch_i = 1; funct3_i = f3; pc_i = pc; imm_i = imm;
        zero_i = z; cf_i = c;
    endtask

    task automatic cmp(input string name, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        #12;
        cmp("rst valid", N'(valid_o), 0);
        cmp("rst redirect", N'(redirect_o), 0);
        cmp("rst redirect_pc", redirect_pc_o, 0);
        cmp("rst taken_cnt", taken_cnt_o, 0);
        cmp("rst reg_write", N'(reg_write_o), 0);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_beq();
        drive_branch(3'b000, 32'h100, 32'h20, 1'b1, 1'b0);
        tick();
        cmp("beq redirect", N'(redirect_o), 1);
        cmp("beq target", redirect_pc_o, 32'h120);
        cmp("beq cnt", taken_cnt_o, 1);
        cmp("beq misalign", N'(misalign_o), 0);
        cmp("beq valid", N'(valid_o), 1);
        drive_alu(32'h5, 5'd3);
        tick();
        cmp("beq kill valid", N'(valid_o), 0);
        cmp("beq kill reg_write", N'(reg_write_o), 0);
        cmp("beq kill redirect", N'(redirect_o), 0);
        tick();
        cmp("beq after valid", N'(valid_o), 1);
        cmp("beq after result", result_o, 32'h5);
        cmp("beq after rd", N'(rd_o), 3);
    endtask

    task automatic test_bltu_bgeu();
        drive_branch(3'b110, 32'h500, 32'h40, 1'b0, 1'b1);
        tick();
        cmp("bltu redirect", N'(redirect_o), 0);
        cmp("bltu valid", N'(valid_o), 1);
        cmp("bltu cnt", taken_cnt_o, 1);
        // Target wraps past 2^32
        drive_branch(3'b111, 32'hFFFF_FFF8, 32'h10, 1'b0, 1'b1);
        tick();
        cmp("bgeu redirect", N'(redirect_o), 1);
        cmp("bgeu target wrap", redirect_pc_o, 32'h8);
        cmp("bgeu cnt", taken_cnt_o, 2);
        drive_idle();
        tick();  // consumes the kill slot
        // funct3 010 never branches even with zero set
        drive_branch(3'b010, 32'h10, 32'h4, 1'b1, 1'b1);
        tick();
        cmp("f3_010 redirect", N'(redirect_o), 0);
        cmp("f3_010 cnt", taken_cnt_o, 2);
    endtask

    task automatic test_jalr();
        drive_idle();
        valid_i = 1; jalr_i = 1; alu_out_i = 32'h2003; pc_i = 32'h40;
        imm_i = 32'h3; rd_i = 5'd1; reg_write_i = 1;
        tick();
        cmp("jalr target", redirect_pc_o, 32'h2002);
        cmp("jalr result", result_o, 32'h44);
        cmp("jalr reg_write", N'(reg_write_o), 1);
        cmp("jalr misalign", N'(misalign_o), 1);
        cmp("jalr cnt", taken_cnt_o, 3);
        drive_idle();
        tick();
    endtask

    task automatic test_stall();
        drive_branch(3'b001, 32'h200, 32'hFFFF_FFF0, 1'b0, 1'b0);
        tick();
        cmp("bne redirect", N'(redirect_o), 1);
        cmp("bne target", redirect_pc_o, 32'h1F0);
        cmp("bne cnt", taken_cnt_o, 4);
        drive_alu(32'h77, 5'd7);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall redirect", N'(redirect_o), 0);
            cmp("stall valid", N'(valid_o), 1);
            cmp("stall target", redirect_pc_o, 32'h1F0);
            cmp("stall cnt", taken_cnt_o, 4);
        end
        stall_i = 0;
        tick();
        cmp("post-stall kill valid", N'(valid_o), 0);
        tick();
        cmp("post-stall valid", N'(valid_o), 1);
        cmp("post-stall result", result_o, 32'h77);
    endtask

    task automatic test_flush_stall();
        drive_idle();
        valid_i = 1; jal_i = 1; pc_i = 32'h300; imm_i = 32'h8;
        rd_i = 5'd1; reg_write_i = 1;
        tick();
        cmp("jal target", redirect_pc_o, 32'h308);
        cmp("jal result", result_o, 32'h304);
        cmp("jal cnt", taken_cnt_o, 5);
        drive_alu(32'h55, 5'd2);
        flush_i = 1; stall_i = 1;
        tick();
        cmp("flush valid", N'(valid_o), 0);
        cmp("flush redirect", N'(redirect_o), 0);
        cmp("flush reg_write", N'(reg_write_o), 0);
        drive_alu(32'h99, 5'd4);
        tick();
        cmp("after flush valid", N'(valid_o), 1);
        cmp("after flush result", result_o, 32'h99);
    endtask

    task automatic test_bubble();
        drive_idle();
        jal_i = 1; pc_i = 32'h600; imm_i = 32'h10; reg_write_i = 1;
        mem_write_i = 1;
        tick();
        cmp("bubble redirect", N'(redirect_o), 0);
        cmp("bubble cnt", taken_cnt_o, 5);
        cmp("bubble valid", N'(valid_o), 0);
        cmp("bubble mem_write", N'(mem_write_o), 0);
    endtask

    task automatic test_async_reset();
        drive_branch(3'b000, 32'h700, 32'h4, 1'b1, 1'b0);
        tick();
        cmp("pre-rst redirect", N'(redirect_o), 1);
        drive_idle();
        #2;
        rst_n = 0;
        #1;
        cmp("async redirect", N'(redirect_o), 0);
        cmp("async valid", N'(valid_o), 0);
        cmp("async target", redirect_pc_o, 0);
        cmp("async cnt", taken_cnt_o, 0);
        #2;
        rst_n = 1;
        drive_alu(32'hAB, 5'd9);
        tick();
        cmp("post-rst no kill valid", N'(valid_o), 1);
        cmp("post-rst result", result_o, 32'hAB);
    endtask

    initial begin
        test_reset();
        test_beq();
        test_bltu_bgeu();
        test_jalr();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
